display_timings: RTL and testbench
==================================

Name: display_timings

Overview:
- Parameterised display timing generator.
- Sits directly upstream of the paint/colour stage and the SDL output stage.
- Produces screen coordinates, sync, data enable, and line/frame strobes for one pixel clock domain.
- Replaces the fixed 480p generator. Reset is asynchronous active-low; all outputs are registered and mutually aligned.

Parameters:
- CORDW, 10, coordinate width; must hold H_TOTAL-1 and V_TOTAL-1.
- FCW, 16, frame counter width.
- H_RES, 640, active pixels per line.
- H_FP, 16, horizontal front porch.
- H_SYNC, 96, horizontal sync width (>=1).
- H_BP, 48, horizontal back porch.
- V_RES, 480, active lines.
- V_FP, 10, vertical front porch.
- V_SYNC, 2, vertical sync width (>=1).
- V_BP, 33, vertical back porch.
- H_POL, 0, hsync active level (0 = active-low).
- V_POL, 0, vsync active level.
- Derived: H_TOTAL = H_RES+H_FP+H_SYNC+H_BP (800); V_TOTAL likewise (525).

Ports:
- clk_pix  input  1  pixel clock.
- rst_pix_n  input  1  asynchronous active-low reset.
- sx  output  CORDW  horizontal position, 0..H_TOTAL-1.
- sy  output  CORDW  vertical position, 0..V_TOTAL-1.
- hsync  output  1  horizontal sync, polarity per H_POL.
- vsync  output  1  vertical sync, polarity per V_POL.
- de  output  1  data enable, high in active area.
- line  output  1  one-cycle strobe at sx==0 on every line.
- frame  output  1  one-cycle strobe at sx==0, sy==0.
- frame_cnt  output  FCW  frames started since reset.

Behaviour:
- Reset values (held asynchronously while rst_pix_n=0, applied immediately on assertion, independent of clock):
  - sx=H_TOTAL-1, sy=V_TOTAL-1.
  - hsync=~H_POL, vsync=~V_POL.
  - de=0, line=0, frame=0.
  - frame_cnt=all ones.
- Structure: next-state logic computes the next sx/sy and decodes every other output from those next values. All outputs register together on the rising edge of clk_pix. Every output therefore describes the same (sx,sy) in the same cycle; decode-to-output latency is zero relative to sx/sy.
- Counting:
  - sx increments each cycle.
  - At sx==H_TOTAL-1, sx wraps to 0 and sy increments.
  - At sx==H_TOTAL-1 and sy==V_TOTAL-1, both wrap to 0.
  - There is no stall or enable; the counters free-run.
- Decodes, applied to the registered sx/sy:
  - de = (sx<H_RES) && (sy<V_RES).
  - hsync = H_POL when H_RES+H_FP <= sx <= H_RES+H_FP+H_SYNC-1 (656..751), else ~H_POL.
  - vsync = V_POL when V_RES+V_FP <= sy <= V_RES+V_FP+V_SYNC-1 (490..491), else ~V_POL. vsync is a function of sy only and changes with the sx=0 transition.
  - line = (sx==0).
  - frame = (sx==0 && sy==0).
- frame_cnt:
  - Increments (mod 2^FCW) in the same cycle frame goes high.
  - Reset value of all ones makes the first frame read 0.
  - Wraps from 2^FCW-1 to 0 with no flag.
- First edge after reset release: sx=0, sy=0, de=1, line=1, frame=1, frame_cnt=0.
- Reset mid-frame: all outputs snap to reset values asynchronously. Release restarts at (0,0) as above; no partial-frame continuation.
- Reset release is assumed synchronised externally; no internal synchroniser.
- Widths: all comparisons in CORDW-bit unsigned arithmetic.
- Elaboration: a parameter set with H_TOTAL-1 or V_TOTAL-1 >= 2^CORDW must fail with $error.

Test Plan:
- Reset then release: while reset, sx=799, sy=524, de=0, hsync=1, vsync=1, frame_cnt=16'hFFFF. First edge after release: sx=0, sy=0, de=1, frame=1, line=1, frame_cnt=0.
- One line: de high for exactly 640 cycles (sx 0..639). hsync low exactly for sx 656..751 (96 cycles). line pulses once per 800 cycles.
- One frame (420000 cycles): de high for 307200 cycles total. vsync low for sy 490..491 (1600 cycles). frame pulses once. frame_cnt goes 0 -> 1 at the next (0,0).
- Wrap: at sx=799, sy=524, the next edge gives sx=0, sy=0 with frame=1. At sx=799, sy=100, the next edge gives sx=0, sy=101 with line=1, frame=0.
- Async reset mid-frame at sx=300, sy=200, asserted between clock edges: outputs switch to reset values without waiting for a clock edge. After release, sequence restarts at (0,0) and frame_cnt=0.
- Polarity/params: H_POL=1, V_POL=1 with small timing (H_RES=8, H_FP=1, H_SYNC=2, H_BP=1, V_RES=4, V_FP=1, V_SYNC=1, V_BP=1). hsync high only at sx 9..10, vsync high only at sy 5. Frame period = 12*7 = 84 cycles.

Source files
------------

// File: rtl/display_timings.sv
// Display timing generator: free-running pixel/line counters with sync, data
// enable and line/frame strobes, all registered together so every output
// describes the same (sx, sy) in the same cycle.
module display_timings #(
    parameter int unsigned CORDW  = 10,
    parameter int unsigned FCW    = 16,
    parameter int unsigned H_RES  = 640,
    parameter int unsigned H_FP   = 16,
    parameter int unsigned H_SYNC = 96,
    parameter int unsigned H_BP   = 48,
    parameter int unsigned V_RES  = 480,
    parameter int unsigned V_FP   = 10,
    parameter int unsigned V_SYNC = 2,
    parameter int unsigned V_BP   = 33,
    parameter int unsigned H_POL  = 0,
    parameter int unsigned V_POL  = 0
) (
    input  logic             clk_pix,
    input  logic             rst_pix_n,
    output logic [CORDW-1:0] sx,
    output logic [CORDW-1:0] sy,
    output logic             hsync,
    output logic             vsync,
    output logic             de,
    output logic             line,
    output logic             frame,
    output logic [FCW-1:0]   frame_cnt
);

    localparam int unsigned H_TOTAL = H_RES + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_RES + V_FP + V_SYNC + V_BP;

    localparam logic [CORDW-1:0] L_H_MAX    = CORDW'(H_TOTAL - 1);
    localparam logic [CORDW-1:0] L_V_MAX    = CORDW'(V_TOTAL - 1);
    localparam logic [CORDW-1:0] L_H_RES    = CORDW'(H_RES);
    localparam logic [CORDW-1:0] L_V_RES    = CORDW'(V_RES);
    localparam logic [CORDW-1:0] L_HS_START = CORDW'(H_RES + H_FP);
    localparam logic [CORDW-1:0] L_HS_END   = CORDW'(H_RES + H_FP + H_SYNC - 1);
    localparam logic [CORDW-1:0] L_VS_START = CORDW'(V_RES + V_FP);
    localparam logic [CORDW-1:0] L_VS_END   = CORDW'(V_RES + V_FP + V_SYNC - 1);
    localparam logic [CORDW-1:0] L_C_ONE    = CORDW'(1);
    localparam logic [FCW-1:0]   L_F_ONE    = FCW'(1);
    localparam logic             L_HPOL     = (H_POL != 0);
    localparam logic             L_VPOL     = (V_POL != 0);

    // Counters must be able to hold the last position of a line and a frame.
    if ((longint'(H_TOTAL) - 1) >= (longint'(1) << CORDW)) begin : g_bad_h_total
        $error("display_timings: H_TOTAL-1 does not fit in CORDW bits");
    end
    if ((longint'(V_TOTAL) - 1) >= (longint'(1) << CORDW)) begin : g_bad_v_total
        $error("display_timings: V_TOTAL-1 does not fit in CORDW bits");
    end

    logic [CORDW-1:0] r_sx, r_sy;
    logic             r_hsync, r_vsync, r_de, r_line, r_frame;
    logic [FCW-1:0]   r_fcnt;

    logic [CORDW-1:0] w_sx_next, w_sy_next;
    logic             w_hsync_next, w_vsync_next, w_de_next, w_line_next, w_frame_next;
    logic [FCW-1:0]   w_fcnt_next;

    // Next position, then every other output decoded from that next position so
    // the registered outputs line up with the registered coordinates.
    always_comb begin
        w_sx_next = r_sx + L_C_ONE;
        w_sy_next = r_sy;
        if (r_sx == L_H_MAX) begin
            w_sx_next = '0;
            if (r_sy == L_V_MAX) begin
                w_sy_next = '0;
            end else begin
                w_sy_next = r_sy + L_C_ONE;
            end
        end

        w_de_next    = (w_sx_next < L_H_RES) && (w_sy_next < L_V_RES);
        w_hsync_next = ((w_sx_next >= L_HS_START) && (w_sx_next <= L_HS_END)) ? L_HPOL : ~L_HPOL;
        w_vsync_next = ((w_sy_next >= L_VS_START) && (w_sy_next <= L_VS_END)) ? L_VPOL : ~L_VPOL;
        w_line_next  = (w_sx_next == '0);
        w_frame_next = w_line_next && (w_sy_next == '0);
        // Counter rests at all ones so the first frame after reset reads zero.
        w_fcnt_next  = w_frame_next ? (r_fcnt + L_F_ONE) : r_fcnt;
    end

    // Output registers; reset parks on the last pixel so release starts at (0,0).
    always_ff @(posedge clk_pix or negedge rst_pix_n) begin
        if (!rst_pix_n) begin
            r_sx    <= L_H_MAX;
            r_sy    <= L_V_MAX;
            r_hsync <= ~L_HPOL;
            r_vsync <= ~L_VPOL;
            r_de    <= 1'b0;
            r_line  <= 1'b0;
            r_frame <= 1'b0;
            r_fcnt  <= '1;
        end else begin
            r_sx    <= w_sx_next;
            r_sy    <= w_sy_next;
            r_hsync <= w_hsync_next;
            r_vsync <= w_vsync_next;
            r_de    <= w_de_next;
            r_line  <= w_line_next;
            r_frame <= w_frame_next;
            r_fcnt  <= w_fcnt_next;
        end
    end

    assign sx        = r_sx;
    assign sy        = r_sy;
    assign hsync     = r_hsync;
    assign vsync     = r_vsync;
    assign de        = r_de;
    assign line      = r_line;
    assign frame     = r_frame;
    assign frame_cnt = r_fcnt;

endmodule

// File: tb/tb_display_timings.sv
// Bench for display_timings: a default 640x480 instance and a small
// positive-polarity instance share clock and reset. A cycle-count model gives
// the expected outputs every cycle; directed literals pin key points.
module tb_display_timings;

    typedef struct packed {
        logic [31:0] sx;
        logic [31:0] sy;
        logic        hs;
        logic        vs;
        logic        de;
        logic        ln;
        logic        fr;
        logic [31:0] fc;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    bit   run = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;
    longint n_cyc = -1;

    logic [9:0]  b_sx, b_sy;
    logic        b_hs, b_vs, b_de, b_ln, b_fr;
    logic [15:0] b_fc;
    logic [3:0]  s_sx, s_sy;
    logic        s_hs, s_vs, s_de, s_ln, s_fr;
    logic [2:0]  s_fc;

    always #5 clk = ~clk;

    display_timings u_big (
        .clk_pix   (clk),
        .rst_pix_n (rst_n),
        .sx        (b_sx),
        .sy        (b_sy),
        .hsync     (b_hs),
        .vsync     (b_vs),
        .de        (b_de),
        .line      (b_ln),
        .frame     (b_fr),
        .frame_cnt (b_fc)
    );

    display_timings #(
        .CORDW(4), .FCW(3),
        .H_RES(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_RES(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .H_POL(1), .V_POL(1)
    ) u_small (
        .clk_pix   (clk),
        .rst_pix_n (rst_n),
        .sx        (s_sx),
        .sy        (s_sy),
        .hsync     (s_hs),
        .vsync     (s_vs),
        .de        (s_de),
        .line      (s_ln),
        .frame     (s_fr),
        .frame_cnt (s_fc)
    );

    // Edges seen since reset release; -1 means in reset.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) n_cyc <= -1;
        else        n_cyc <= n_cyc + 1;
    end

    // Expected outputs purely from elapsed cycles and the timing parameters.
    function automatic vec_t model(input longint n, input int hres, input int hfp,
                                   input int hsw, input int hbp, input int vres,
                                   input int vfp, input int vsw, input int vbp,
                                   input bit hpol, input bit vpol, input int fcw);
        vec_t   e;
        longint htot = hres + hfp + hsw + hbp;
        longint vtot = vres + vfp + vsw + vbp;
        longint m    = longint'(1) << fcw;
        longint x, y, f;
        if (n < 0) begin
            e.sx = 32'(htot - 1);
            e.sy = 32'(vtot - 1);
            e.hs = ~hpol;
            e.vs = ~vpol;
            e.de = 1'b0;
            e.ln = 1'b0;
            e.fr = 1'b0;
            e.fc = 32'(m - 1);
        end else begin
            x = n % htot;
            y = (n / htot) % vtot;
            f = n / (htot * vtot);
            e.sx = 32'(x);
            e.sy = 32'(y);
            e.hs = (x >= hres + hfp && x < hres + hfp + hsw) ? hpol : ~hpol;
            e.vs = (y >= vres + vfp && y < vres + vfp + vsw) ? vpol : ~vpol;
            e.de = (x < hres) && (y < vres);
            e.ln = (x == 0);
            e.fr = (x == 0) && (y == 0);
            e.fc = 32'(f % m);
        end
        return e;
    endfunction

    function automatic vec_t act_big();
        vec_t a;
        a.sx = 32'(b_sx); a.sy = 32'(b_sy);
        a.hs = b_hs; a.vs = b_vs; a.de = b_de; a.ln = b_ln; a.fr = b_fr;
        a.fc = 32'(b_fc);
        return a;
    endfunction

    function automatic vec_t act_small();
        vec_t a;
        a.sx = 32'(s_sx); a.sy = 32'(s_sy);
        a.hs = s_hs; a.vs = s_vs; a.de = s_de; a.ln = s_ln; a.fr = s_fr;
        a.fc = 32'(s_fc);
        return a;
    endfunction

    task automatic check_vec(input string name, input vec_t a, input vec_t e);
        n_cmp++;
        if (a !== e) begin
            n_err++;
            $display("FAIL %s n=%0d got sx=%0d sy=%0d hs=%b vs=%b de=%b ln=%b fr=%b fc=%0d want sx=%0d sy=%0d hs=%b vs=%b de=%b ln=%b fr=%b fc=%0d",
                     name, n_cyc, a.sx, a.sy, a.hs, a.vs, a.de, a.ln, a.fr, a.fc,
                     e.sx, e.sy, e.hs, e.vs, e.de, e.ln, e.fr, e.fc);
        end
    endtask

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s got %0d want %0d", name, act, exp);
        end
    endtask

    // Compare both instances against the model on every falling edge.
    always @(negedge clk) begin
        if (run) begin
            check_vec("big", act_big(), model(n_cyc, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0, 16));
            check_vec("small", act_small(), model(n_cyc, 8, 1, 2, 1, 4, 1, 1, 1, 1'b1, 1'b1, 3));
        end
    end

    initial begin
        int de_cnt = 0, hs_cnt = 0, ln_cnt = 0, hs_first = -1, hs_last = -1;
        int sfr_cnt = 0, shs_cnt = 0, svs_cnt = 0;
        int shs_min = 99, shs_max = -1, svs_min = 99, svs_max = -1;

        #1 rst_n = 1'b0;
        run = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_big_sx", b_sx, 799);
        check("rst_big_sy", b_sy, 524);
        check("rst_big_de", b_de, 0);
        check("rst_big_hs", b_hs, 1);
        check("rst_big_vs", b_vs, 1);
        check("rst_big_fr", b_fr, 0);
        check("rst_big_fc", b_fc, 16'hFFFF);
        check("rst_small_sx", s_sx, 11);
        check("rst_small_sy", s_sy, 6);
        check("rst_small_hs", s_hs, 0);
        check("rst_small_vs", s_vs, 0);
        check("rst_small_fc", s_fc, 7);

        @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("first_sx", b_sx, 0);
        check("first_sy", b_sy, 0);
        check("first_de", b_de, 1);
        check("first_ln", b_ln, 1);
        check("first_fr", b_fr, 1);
        check("first_fc", b_fc, 0);
        check("first_small_fr", s_fr, 1);
        check("first_small_fc", s_fc, 0);

        // One full default line; the small instance runs ten frames meanwhile.
        for (int i = 0; i < 800; i++) begin
            if (b_de) de_cnt++;
            if (!b_hs) begin
                hs_cnt++;
                if (hs_first < 0) hs_first = int'(b_sx);
                hs_last = int'(b_sx);
            end
            if (b_ln) ln_cnt++;
            if (s_fr) sfr_cnt++;
            if (s_hs) begin
                shs_cnt++;
                if (int'(s_sx) < shs_min) shs_min = int'(s_sx);
                if (int'(s_sx) > shs_max) shs_max = int'(s_sx);
            end
            if (s_vs) begin
                svs_cnt++;
                if (int'(s_sy) < svs_min) svs_min = int'(s_sy);
                if (int'(s_sy) > svs_max) svs_max = int'(s_sy);
            end
            if (i < 799) begin
                @(posedge clk);
                #1;
            end
        end
        check("line_de_cycles", de_cnt, 640);
        check("line_hs_cycles", hs_cnt, 96);
        check("line_hs_first", hs_first, 656);
        check("line_hs_last", hs_last, 751);
        check("line_pulses", ln_cnt, 1);
        check("line_end_sx", b_sx, 799);
        check("line_end_sy", b_sy, 0);
        check("small_frames", sfr_cnt, 10);
        check("small_hs_cycles", shs_cnt, 132);
        check("small_hs_min", shs_min, 9);
        check("small_hs_max", shs_max, 10);
        check("small_vs_cycles", svs_cnt, 108);
        check("small_vs_min", svs_min, 5);
        check("small_vs_max", svs_max, 5);
        check("small_fc_wrapped", s_fc, 1);

        @(posedge clk);
        #1;
        check("wrap_line_sx", b_sx, 0);
        check("wrap_line_sy", b_sy, 1);
        check("wrap_line_ln", b_ln, 1);
        check("wrap_line_fr", b_fr, 0);

        // Advance to (300,2) and pull reset between edges.
        repeat (1100) @(posedge clk);
        #1;
        check("mid_sx", b_sx, 300);
        check("mid_sy", b_sy, 2);
        #2 rst_n = 1'b0;
        #1;
        check("async_sx", b_sx, 799);
        check("async_sy", b_sy, 524);
        check("async_de", b_de, 0);
        check("async_fc", b_fc, 16'hFFFF);
        check("async_small_sx", s_sx, 11);

        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("restart_sx", b_sx, 0);
        check("restart_sy", b_sy, 0);
        check("restart_fr", b_fr, 1);
        check("restart_fc", b_fc, 0);
        check("restart_small_fc", s_fc, 0);

        // Small instance frame wrap: (11,6) -> (0,0) with frame strobe.
        repeat (83) @(posedge clk);
        #1;
        check("swrap_pre_sx", s_sx, 11);
        check("swrap_pre_sy", s_sy, 6);
        check("swrap_pre_fr", s_fr, 0);
        check("swrap_pre_big_sx", b_sx, 83);
        @(posedge clk);
        #1;
        check("swrap_sx", s_sx, 0);
        check("swrap_sy", s_sy, 0);
        check("swrap_fr", s_fr, 1);
        check("swrap_fc", s_fc, 1);
        check("swrap_big_ln", b_ln, 0);

        repeat (2000) @(posedge clk);
        #1;
        run = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
